// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// default widths, FUNCT3 op codes and the FSM state encoding.
package muldiv_pkg;

   localparam int XLEN_DEF       = 32;
   localparam int REG_ADDR_W_DEF = 5;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step on unsigned magnitudes: shift-add multiply or restoring divide.
// The accumulator is {high half, low half}; the low half holds multiplier or dividend/quotient.
module muldiv_iter #(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   operand,
   input  logic              div_mode,
   output logic [2*XLEN-1:0] acc_next,
   output logic              q_bit
);

   logic [XLEN:0] sum;
   logic [XLEN:0] part;
   logic [XLEN:0] diff;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      acc_next = acc;
      q_bit    = 1'b0;
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
      part     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff     = part - {1'b0, operand};
      if (div_mode) begin
         // The vacated lsb is left clear; the caller merges q_bit into it.
         q_bit    = ~diff[XLEN];
         acc_next = {(q_bit ? diff[XLEN-1:0] : part[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
      end else begin
         acc_next = {sum, acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute stage: IDLE -> CALC -> FIX -> DONE -> IDLE,
// operating on magnitudes with a sign fix-up, plus a fast path for divide special cases.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [XLEN-1:0]       op_a,
   input  logic [XLEN-1:0]       op_b,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [XLEN-1:0]       result,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic                  wb_en
);

   localparam int                CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(XLEN - 1);

   state_t                  state, state_d;
   logic [CNT_W-1:0]        cnt;
   logic [2*XLEN-1:0]       acc, acc_step;
   logic [XLEN-1:0]         opnd;
   logic [2:0]              f3_q;
   logic [REG_ADDR_W-1:0]   rd_q;
   logic                    neg_q, special_q, q_bit;

   logic                    a_neg, b_neg, res_neg, div_zero, div_ovf, special, accept;
   logic [XLEN-1:0]         a_mag, b_mag, special_val, fix_res;
   logic [2*XLEN-1:0]       prod;
   logic                    busy_d, done_d, wb_en_d;

   // Operand decode for the instruction presented at the accepting edge.
   always_comb begin
      a_neg       = (funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && op_a[XLEN-1];
      b_neg       = (funct3 inside {F3_MULH, F3_DIV, F3_REM}) && op_b[XLEN-1];
      a_mag       = a_neg ? -op_a : op_a;
      b_mag       = b_neg ? -op_b : op_b;
      div_zero    = funct3[2] && (op_b == '0);
      div_ovf     = (funct3 inside {F3_DIV, F3_REM}) && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                    && (op_b == '1);
      special     = div_zero || div_ovf;
      special_val = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
      case (funct3)
         F3_MULH, F3_DIV:  res_neg = a_neg ^ b_neg;
         F3_MULHSU, F3_REM: res_neg = a_neg;
         default:          res_neg = 1'b0;
      endcase
   end

   assign accept = (state == S_IDLE) && start && !flush;

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .acc      (acc),
      .operand  (opnd),
      .div_mode (f3_q[2]),
      .acc_next (acc_step),
      .q_bit    (q_bit)
   );

   always_comb begin
      state_d = state;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state_d = special ? S_FIX : S_CALC;
            S_CALC:  if (cnt == LAST) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      wb_en_d = done_d && (rd_q != '0);
   end

   // Sign correction and result selection, consumed only in FIX.
   always_comb begin
      prod = neg_q ? -acc : acc;
      if (special_q) begin
         fix_res = acc[XLEN-1:0];
      end else begin
         case (f3_q)
            F3_MUL:                       fix_res = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            default:                      fix_res = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         wb_en   <= 1'b0;
         result  <= '0;
         wb_addr <= '0;
      end else begin
         state <= state_d;
         busy  <= busy_d;
         done  <= done_d;
         wb_en <= wb_en_d;
         if (state == S_FIX && !flush) begin
            result  <= fix_res;
            wb_addr <= rd_q;
         end
      end
   end

   // NOTE: datapath registers carry no reset; they are always loaded at accept before being read.
   always_ff @(posedge clk) begin
      if (accept) begin
         f3_q      <= funct3;
         rd_q      <= rd_addr;
         neg_q     <= res_neg;
         special_q <= special;
         cnt       <= '0;
         opnd      <= funct3[2] ? b_mag : a_mag;
         if (special)        acc <= {{XLEN{1'b0}}, special_val};
         else if (funct3[2]) acc <= {{XLEN{1'b0}}, a_mag};
         else                acc <= {{XLEN{1'b0}}, b_mag};
      end else if (state == S_CALC) begin
         acc <= {acc_step[2*XLEN-1:1], acc_step[0] | q_bit};
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and scoreboarded checks of muldiv_unit: results, latency, handshake, flush and reset.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, start, flush;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b, result;
   logic [4:0]  rd_addr, wb_addr;
   logic        busy, done, wb_en;

   int n_checks = 0;
   int n_pass   = 0;
   int n_done   = 0;

   always #5 clk = ~clk;
   always @(negedge clk) if (done) n_done++;

   muldiv_unit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .funct3  (funct3),
      .op_a    (op_a),
      .op_b    (op_b),
      .rd_addr (rd_addr),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .wb_addr (wb_addr),
      .wb_en   (wb_en)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      funct3  = f3;
      op_a    = a;
      op_b    = b;
      rd_addr = rd;
      start   = 1'b1;
   endtask

   // Called at the negedge right after the accepting edge; lat counts that edge as 1.
   task automatic wait_done(output int lat, output logic busy_ok);
      lat     = 1;
      busy_ok = 1'b1;
      while (!done && lat < 100) begin
         if (!busy) busy_ok = 1'b0;
         step(1);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int exp_lat);
      int   lat;
      logic busy_ok;
      drive(f3, a, b, rd);
      step(1);
      start = 1'b0;
      wait_done(lat, busy_ok);
      check({tag, "_res"}, result, exp);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy"}, {31'd0, busy_ok & busy}, 32'd1);
      check({tag, "_wbaddr"}, {27'd0, wb_addr}, {27'd0, rd});
      check({tag, "_wben"}, {31'd0, wb_en}, {31'd0, rd != 5'd0});
      step(1);
      check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0]        ua, ub, p;
      logic signed [31:0] sq;
      logic               ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         F3_MUL:    begin p = ua * ub;             return p[31:0];  end
         F3_MULH:   begin p = sa * sb;             return p[63:32]; end
         F3_MULHSU: begin p = sa * $signed(ub);    return p[63:32]; end
         F3_MULHU:  begin p = ua * ub;             return p[63:32]; end
         F3_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            sq = $signed(a) / $signed(b);
            return sq;
         end
         F3_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         F3_REM: begin
            if (b == 32'd0) return a;
            if (ovf) return 32'd0;
            sq = $signed(a) % $signed(b);
            return sq;
         end
         default:   return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   initial begin
      int          d0, lat;
      logic        busy_ok;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int          exp_lat;

      rst_n = 1'b0; start = 1'b0; flush = 1'b0;
      funct3 = 3'd0; op_a = '0; op_b = '0; rd_addr = '0;
      step(3);
      rst_n = 1'b1;
      check("rst_outs", {27'd0, busy, done, wb_en, 2'd0}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_wbaddr", {27'd0, wb_addr}, 32'd0);

      // Multiply
      run_op("mul_7x6", F3_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 34);
      run_op("mulhu_ff", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 34);
      run_op("mulhsu_m1", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 34);

      // Divide
      run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 34);
      run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 34);
      run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 5'd10, 32'd14, 34);
      run_op("remu_100_7", F3_REMU, 32'd100, 32'd7, 5'd11, 32'd2, 34);

      // Fast-path special cases
      run_op("div_by0", F3_DIV, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 2);
      run_op("rem_by0", F3_REM, 32'd5, 32'd0, 5'd13, 32'd5, 2);
      run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 2);
      run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 2);

      // START mid-CALC and in the DONE cycle is ignored
      d0 = n_done;
      drive(F3_MUL, 32'd3, 32'd4, 5'd3);
      step(1);
      start = 1'b0;
      step(10);
      drive(F3_DIV, 32'd100, 32'd5, 5'd9);
      step(1);
      start = 1'b0;
      wait_done(lat, busy_ok);
      check("ign_res", result, 32'd12);
      drive(F3_DIV, 32'd100, 32'd5, 5'd9);
      step(1);
      start = 1'b0;
      check("ign_busy", {31'd0, busy}, 32'd0);
      step(40);
      check("ign_ndone", 32'(n_done - d0), 32'd1);
      check("ign_keep", result, 32'd12);

      // Back-to-back: upstream holds START until it sees !BUSY
      drive(F3_DIVU, 32'd100, 32'd7, 5'd2);
      step(1);
      drive(F3_REMU, 32'd100, 32'd7, 5'd3);
      wait_done(lat, busy_ok);
      check("b2b_first", result, 32'd14);
      step(1);
      check("b2b_gap", {31'd0, busy}, 32'd0);
      step(1);
      start = 1'b0;
      check("b2b_acc", {31'd0, busy}, 32'd1);
      wait_done(lat, busy_ok);
      check("b2b_second", result, 32'd2);
      check("b2b_lat", 32'(lat), 32'd34);
      step(1);

      // FLUSH at count=10
      drive(F3_MUL, 32'd1000, 32'd1000, 5'd7);
      step(1);
      start = 1'b0;
      step(10);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      d0 = n_done;
      step(40);
      check("flush_ndone", 32'(n_done - d0), 32'd0);
      check("flush_keep", result, 32'd2);

      // FLUSH in IDLE wins over START
      drive(F3_MUL, 32'd2, 32'd2, 5'd1);
      flush = 1'b1;
      step(1);
      start = 1'b0;
      flush = 1'b0;
      check("flidle_busy", {31'd0, busy}, 32'd0);
      step(3);
      check("flidle_busy2", {31'd0, busy}, 32'd0);

      // rd = 0: DONE without write enable
      run_op("rd0", F3_MUL, 32'd7, 32'd6, 5'd0, 32'd42, 34);

      // Reset mid-CALC
      drive(F3_MUL, 32'd5, 32'd5, 5'd4);
      step(1);
      start = 1'b0;
      step(5);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      check("mrst_outs", {27'd0, busy, done, wb_en, 2'd0}, 32'd0);
      check("mrst_result", result, 32'd0);
      check("mrst_wbaddr", {27'd0, wb_addr}, 32'd0);
      d0 = n_done;
      step(40);
      check("mrst_ndone", 32'(n_done - d0), 32'd0);

      // Scoreboard all FUNCT3 values on random operands
      for (int f = 0; f < 8; f++) begin
         for (int k = 0; k < 3; k++) begin
            a  = $urandom;
            b  = (k == 2) ? 32'($urandom_range(1, 100)) : $urandom;
            rd = 5'($urandom_range(0, 31));
            exp_lat = (f >= 4 && (b == 32'd0 || ((f == 4 || f == 6) && a == 32'h8000_0000
                      && b == 32'hFFFF_FFFF))) ? 2 : 34;
            run_op($sformatf("rnd_f%0d_%0d", f, k), 3'(f), a, b, rd, ref_model(3'(f), a, b),
                   exp_lat);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
